imem_boot_loader: RTL and testbench

//  Writer side of the processor's instruction-fetch path: receives a program as a byte stream (valid/ready),

---
 rtl/imem_boot_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a program image as a byte stream, packs little-endian
// 32-bit words into instruction memory, and holds the processor in reset until the
// image checksum verifies.
// Packet: LEN_LO, LEN_HI (N words), 4*N instruction bytes, CSUM (XOR of instruction bytes).
// Ports:
//   clk, reset (sync, active-low)    clock / reset
//   start                            restart a load from DONE or ERR
//   in_valid, in_data, in_ready      byte stream handshake
//   mem_we, mem_addr, mem_wdata      instruction-memory write port (one-cycle strobe)
//   cpu_reset                        processor reset, released after a verified load
//   done, error, error_code          load status (01 length, 10 checksum, 11 timeout)
module imem_boot_loader #(
  parameter int unsigned DEPTH_W = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [DEPTH_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               error,
  output logic [1:0]         error_code
);

  localparam int unsigned CNT_W = DEPTH_W + 1;
  localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [16:0] CAPACITY = 17'(1) << DEPTH_W;

  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t             state;
  logic [7:0]         len_lo;
  logic [CNT_W-1:0]   nwords;
  logic [CNT_W-1:0]   word_cnt;
  logic [1:0]         byte_cnt;
  logic [23:0]        word_buf;
  logic [7:0]         csum;
  logic [TMR_W-1:0]   tmr;

  logic               xfer_c;
  logic [15:0]        len_c;
  logic               timing_c;
  logic               tmo_c;

  assign xfer_c   = in_valid & in_ready;
  assign len_c    = {in_data, len_lo};
  // Idle timer only runs once a packet has started and until its checksum arrives
  assign timing_c = (state == S_LEN1) || (state == S_DATA) || (state == S_CSUM);
  assign tmo_c    = (TIMEOUT != 0) && timing_c && !xfer_c && (32'(tmr) == TIMEOUT - 1);

  // Loader state machine with registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_LEN0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= 2'b00;
      len_lo     <= '0;
      nwords     <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      tmr        <= '0;
    end else begin
      mem_we <= 1'b0;
      if (timing_c) tmr <= xfer_c ? '0 : tmr + TMR_W'(1);

      case (state)
        S_LEN0: begin
          in_ready <= 1'b1;
          if (xfer_c) begin
            len_lo <= in_data;
            tmr    <= '0;
            state  <= S_LEN1;
          end
        end

        S_LEN1: begin
          if (xfer_c) begin
            if (17'(len_c) > CAPACITY) begin
              state      <= S_ERR;
              in_ready   <= 1'b0;
              error      <= 1'b1;
              error_code <= ERR_LEN;
            end else if (len_c == 16'd0) begin
              state <= S_CSUM;
            end else begin
              nwords <= CNT_W'(len_c);
              state  <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer_c) begin
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= DEPTH_W'(word_cnt);
              mem_wdata <= {in_data, word_buf};
              word_cnt  <= word_cnt + CNT_W'(1);
              if (word_cnt == nwords - CNT_W'(1)) state <= S_CSUM;
            end else begin
              word_buf[8*byte_cnt +: 8] <= in_data;
            end
          end
        end

        S_CSUM: begin
          if (xfer_c) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state      <= S_ERR;
              error      <= 1'b1;
              error_code <= ERR_CSUM;
            end
          end
        end

        S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN0;
            in_ready   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            error_code <= 2'b00;
            cpu_reset  <= 1'b1;
            len_lo     <= '0;
            nwords     <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            csum       <= '0;
            tmr        <= '0;
          end
        end

        default: state <= S_LEN0;
      endcase

      // Timeout overrides: it can only fire on a cycle with no transfer
      if (tmo_c) begin
        state      <= S_ERR;
        in_ready   <= 1'b0;
        error      <= 1'b1;
        error_code <= ERR_TMO;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: drives byte packets with random gaps and checks the
// memory writes and final status against a packet-level reference model.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH_W = 8;
  localparam int unsigned TIMEOUT = 16;

  typedef logic [7:0] bq_t[$];

  logic               clk;
  logic               reset;
  logic               start;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               mem_we;
  logic [DEPTH_W-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic               cpu_reset;
  logic               done;
  logic               error;
  logic [1:0]         error_code;

  int checks = 0;
  int errors = 0;

  logic [DEPTH_W-1:0] cap_addr[$];
  logic [31:0]        cap_data[$];

  bq_t t1;

  imem_boot_loader #(.DEPTH_W(DEPTH_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  // Capture every memory write strobe
  always @(negedge clk) begin
    if (reset && mem_we) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) tick();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte: in_ready got 0 want 1 (stalled)");
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_range(input bq_t s, input int lo, input int hi, input int max_gap);
    for (int i = lo; i < hi; i++)
      send_byte(s[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic bq_t make_packet(input int n, input bit bad);
    bq_t s;
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      s.push_back(b);
    end
    if (bad) x = x ^ 8'($urandom_range(255, 1));
    s.push_back(x);
    return s;
  endfunction

  // Reference model: derive writes and status from the packet bytes, compare with DUT
  task automatic check_result(input string name, input bq_t s);
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    logic        exp_done;
    logic [1:0]  exp_code;
    int          exp_writes;
    n = int'(s[0]) + 256 * int'(s[1]);
    x = 8'h00;
    if (n > (1 << DEPTH_W)) begin
      exp_writes = 0;
      exp_done   = 1'b0;
      exp_code   = 2'b01;
    end else begin
      exp_writes = n;
      for (int i = 0; i < 4 * n; i++) x = x ^ s[2 + i];
      exp_done = (s[2 + 4 * n] == x);
      exp_code = exp_done ? 2'b00 : 2'b10;
    end

    checks++;
    if (cap_addr.size() !== exp_writes) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, cap_addr.size(), exp_writes);
    end
    for (int k = 0; k < exp_writes && k < cap_addr.size(); k++) begin
      w = {s[2 + 4*k + 3], s[2 + 4*k + 2], s[2 + 4*k + 1], s[2 + 4*k]};
      checks++;
      if (cap_addr[k] !== DEPTH_W'(k) || cap_data[k] !== w) begin
        errors++;
        $display("FAIL %s write[%0d]: got (%0h,%08h) want (%0h,%08h)",
                 name, k, cap_addr[k], cap_data[k], k, w);
      end
    end
    checks++;
    if (done !== exp_done) begin
      errors++;
      $display("FAIL %s done: got %b want %b", name, done, exp_done);
    end
    checks++;
    if (error !== !exp_done) begin
      errors++;
      $display("FAIL %s error: got %b want %b", name, error, !exp_done);
    end
    checks++;
    if (error_code !== exp_code) begin
      errors++;
      $display("FAIL %s error_code: got %b want %b", name, error_code, exp_code);
    end
    checks++;
    if (cpu_reset !== !exp_done) begin
      errors++;
      $display("FAIL %s cpu_reset: got %b want %b", name, cpu_reset, !exp_done);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready: got %b want 0", name, in_ready);
    end
  endtask

  task automatic run_load(input string name, input bq_t s, input int max_gap);
    if (done || error) do_start();
    cap_addr.delete();
    cap_data.delete();
    send_range(s, 0, s.size(), max_gap);
    repeat (2) tick();
    check_result(name, s);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_port: got rdy=%b we=%b addr=%0h wd=%0h want all 0",
               in_ready, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || error_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_status: got cpu_rst=%b done=%b err=%b code=%b want 1 0 0 00",
               cpu_reset, done, error, error_code);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_t1();
    run_load("t1", t1, 0);
    checks++;
    if (cap_data.size() != 2 || cap_data[0] !== 32'h00500093 || cap_data[1] !== 32'h00108113) begin
      errors++;
      $display("FAIL t1_words: got %0d writes want 00500093,00108113", cap_data.size());
    end
  endtask

  task automatic test_bad_csum();
    bq_t s;
    s = t1;
    s[10] = 8'h42;
    run_load("t2_badcsum", s, 2);
  endtask

  task automatic test_overflow();
    if (done || error) do_start();
    cap_addr.delete();
    cap_data.delete();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if (error !== 1'b1 || error_code !== 2'b01 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL t3_overflow: got err=%b code=%b rdy=%b want 1 01 0", error, error_code, in_ready);
    end
    repeat (4) tick();
    checks++;
    if (cap_addr.size() != 0 || done !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL t3_nowrite: got writes=%0d done=%b cpu_rst=%b want 0 0 1",
               cap_addr.size(), done, cpu_reset);
    end
  endtask

  task automatic test_timeout();
    do_start();
    repeat (40) tick();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL len0_idle: error got %b want 0", error);
    end
    cap_addr.delete();
    cap_data.delete();
    send_range(t1, 0, 5, 0);
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL t4_gap15: error got %b want 0", error);
    end
    send_range(t1, 5, t1.size(), 0);
    repeat (2) tick();
    check_result("t4_gap15", t1);

    do_start();
    cap_addr.delete();
    cap_data.delete();
    send_range(t1, 0, 5, 0);
    repeat (TIMEOUT) tick();
    checks++;
    if (error !== 1'b1 || error_code !== 2'b11 || cpu_reset !== 1'b1 || done !== 1'b0 ||
        in_ready !== 1'b0 || cap_addr.size() != 0) begin
      errors++;
      $display("FAIL t4_gap16: got err=%b code=%b cpu_rst=%b done=%b rdy=%b writes=%0d want 1 11 1 0 0 0",
               error, error_code, cpu_reset, done, in_ready, cap_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    send_range(t1, 0, 7, 0);
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL t5_reset: got rdy=%b cpu_rst=%b done=%b want 0 1 0", in_ready, cpu_reset, done);
    end
    reset = 1'b1;
    tick();
    run_load("t5_after_reset", t1, 0);
  endtask

  task automatic test_zero_len();
    bq_t z;
    z = '{8'h00, 8'h00, 8'h00};
    run_load("t6_zero", z, 0);
    in_valid = 1'b1;
    in_data  = 8'h02;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || error !== 1'b0 || error_code !== 2'b00 || cpu_reset !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL t6_start: got done=%b err=%b code=%b cpu_rst=%b rdy=%b want 0 0 00 1 1",
               done, error, error_code, cpu_reset, in_ready);
    end
    run_load("t6_reload", t1, 0);
  endtask

  task automatic test_start_ignored();
    bq_t s;
    s = make_packet(3, 1'b0);
    do_start();
    cap_addr.delete();
    cap_data.delete();
    send_range(s, 0, 6, 0);
    do_start();
    send_range(s, 6, s.size(), 0);
    repeat (2) tick();
    check_result("start_ignored", s);
  endtask

  task automatic test_back_to_back();
    run_load("b2b_6", make_packet(6, 1'b0), 0);
    run_load("b2b_capacity", make_packet(1 << DEPTH_W, 1'b0), 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_load($sformatf("rand%0d", i),
               make_packet(int'($urandom_range(12, 1)), 1'($urandom_range(1, 0))), 3);
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    t1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h41};
    #1;
    test_reset();
    test_t1();
    test_bad_csum();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_zero_len();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
